axil_wr_arbiter: RTL and testbench
==================================

Name: axil_wr_arbiter

Overview:
Per-slave write-channel arbiter for the priority AXI-Lite interconnect. Selects one of NUMBER_MASTER requesters for one slave port, then holds that grant until the full write transaction (AW, W, B) completes. The interconnect instantiates one per slave. It uses the grant to steer the AW/W mux toward the slave and the B demux back to the winning master. The block is control only and carries no datapath.

Parameters:
NUMBER_MASTER, 4, number of requesting masters (>=2).
IDX_WIDTH, $clog2(NUMBER_MASTER), width of the encoded grant index (derived, do not override).

Ports:
aclk  input  1  clock.
aresetn  input  1  asynchronous active-low reset.
req  input  NUMBER_MASTER  per-master request: m_axil_awvalid[i] AND address decoded to this slave.
aw_hs  input  1  slave-side AW handshake (s_axil_awvalid && s_axil_awready).
w_hs  input  1  slave-side W handshake (s_axil_wvalid && s_axil_wready).
b_hs  input  1  master-side B handshake (bvalid && bready of the granted master).
grant  output  NUMBER_MASTER  one-hot grant, registered.
grant_idx  output  IDX_WIDTH  binary index of the granted master, registered.
busy  output  1  high from grant until the transaction completes.
aw_open  output  1  AW mux enable: high while granted and AW is not yet done.
w_open  output  1  W mux enable: high while granted and W is not yet done.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; grant=0, grant_idx=0, busy=0, aw_open=0, w_open=0.
  - aw_done and w_done flags cleared.
  - Reset mid-transaction aborts immediately. No recovery of the in-flight write.
- FSM states: IDLE, ADDR_DATA, RESP.
- IDLE:
  - If req!=0, pick the winner. Fixed priority: lowest index wins.
  - On the next edge: grant=onehot(winner), grant_idx=winner, busy=1, state=ADDR_DATA.
  - Latency from req to grant is exactly 1 cycle.
  - If req==0, stay in IDLE with all outputs 0.
- ADDR_DATA:
  - aw_open=busy&&!aw_done and w_open=busy&&!w_done, both combinational from the registered state.
  - aw_hs sets aw_done. w_hs sets w_done.
  - AW and W may complete in either order or in the same cycle.
  - Transition to RESP on the edge where (aw_done||aw_hs)&&(w_done||w_hs).
  - aw_hs while aw_done=1, or w_hs while w_done=1, is a protocol error: ignore it; simulation asserts flag it.
- RESP:
  - aw_open=w_open=0.
  - On b_hs, go to IDLE next edge: grant=0, busy=0, flags cleared.
  - Minimum one IDLE cycle between transactions; no back-to-back regrant.
- Grant is never changed while busy. Changes to req during busy (including the granted master's req dropping) are ignored.
- b_hs in IDLE or ADDR_DATA is ignored.
- grant is always one-hot or zero. grant_idx is valid only when busy=1.

Optional Feature:
Macro AXIL_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration. A registered last_idx pointer (reset 0) records the most recent winner.
  - The search starts at last_idx+1, wrapping modulo NUMBER_MASTER.
  - last_idx updates on each grant.
- Undefined:
  - Fixed priority, lowest index wins.
  - No pointer register is instantiated.

Decomposition:
- Package axil_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} arb_state_t;
  - a function onehot_to_idx.
- One combinational sub-module, axil_arb_pick. It takes req and a start pointer and returns the winner one-hot and its index.
  - Fixed priority is the pick with start=0.
  - The same sub-module is reused by a read-channel arbiter (AR/R, two states).

Test Plan:
- Reset then req=4'b0000 for 10 cycles -> grant=0, busy=0, aw_open=w_open=0 throughout.
- req=4'b1010 at cycle 0 -> cycle 1 grant=4'b0010, grant_idx=1; aw_hs cycle 3, w_hs cycle 5 -> RESP at cycle 6; b_hs cycle 8 -> grant=0 at cycle 9.
- Granted master 0; aw_hs and w_hs in the same cycle (cycle 2) -> RESP at cycle 3, aw_open=w_open=0 from cycle 3.
- req=4'b1111 held continuously, fixed priority -> every grant is 4'b0001. With AXIL_ARB_ROUND_ROBIN_EN -> grants cycle 0001,0010,0100,1000,0001.
- Granted master 2 in ADDR_DATA; req changes to 4'b0001 -> grant stays 4'b0100 until b_hs completes.
- aresetn asserted during RESP -> grant=0, busy=0 immediately (asynchronous). After release with req=4'b0100, grant=4'b0100 one cycle later.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// Shared types and helpers for the AXI-Lite channel arbiters.
package axil_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR_DATA,
        RESP
    } arb_state_t;

    localparam int MAX_MASTERS = 32;
    localparam int MAX_IDX_W   = 5;

    // OR-reduction of set-bit positions; exact for one-hot or zero inputs.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axil_arb_pick.sv
// Combinational rotating-priority picker; start_i=0 gives fixed lowest-index priority.
module axil_arb_pick
    import axil_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic found;
    int   pos;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        onehot_o = '0;
        found    = 1'b0;
        pos      = 0;
        for (int off = 0; off < N; off++) begin
            pos = (int'(start_i) + off) % N;
            if (!found && req_i[pos]) begin
                onehot_o[pos] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign idx_o   = IDX_W'(onehot_to_idx(MAX_MASTERS'(onehot_o)));
    assign valid_o = |req_i;

endmodule

// File: rtl/axil_wr_arbiter.sv
// Per-slave AXI-Lite write arbiter: grant held from AW/W through B completion.
// Define AXIL_ARB_ROUND_ROBIN_EN for round-robin instead of fixed lowest-index priority.
module axil_wr_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUMBER_MASTER = 4,
    parameter int IDX_WIDTH     = $clog2(NUMBER_MASTER)
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUMBER_MASTER-1:0] req,
    input  logic                     aw_hs,
    input  logic                     w_hs,
    input  logic                     b_hs,
    output logic [NUMBER_MASTER-1:0] grant,
    output logic [IDX_WIDTH-1:0]     grant_idx,
    output logic                     busy,
    output logic                     aw_open,
    output logic                     w_open
);

    arb_state_t               state_q;
    logic [NUMBER_MASTER-1:0] grant_q;
    logic [IDX_WIDTH-1:0]     grant_idx_q;
    logic                     busy_q;
    logic                     aw_done_q;
    logic                     w_done_q;

    logic [IDX_WIDTH-1:0]     start_ptr;
    logic [NUMBER_MASTER-1:0] pick_onehot;
    logic [IDX_WIDTH-1:0]     pick_idx;
    logic                     pick_valid;

`ifdef AXIL_ARB_ROUND_ROBIN_EN
    logic [IDX_WIDTH-1:0] last_idx_q;

    assign start_ptr = (int'(last_idx_q) == NUMBER_MASTER - 1) ? '0
                                                               : last_idx_q + IDX_WIDTH'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_idx_q <= '0;
        end else if (state_q == IDLE && pick_valid) begin
            last_idx_q <= pick_idx;
        end
    end
`else
    assign start_ptr = '0;
`endif

    axil_arb_pick #(
        .N     (NUMBER_MASTER),
        .IDX_W (IDX_WIDTH)
    ) u_pick (
        .req_i    (req),
        .start_i  (start_ptr),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q     <= pick_onehot;
                        grant_idx_q <= pick_idx;
                        busy_q      <= 1'b1;
                        state_q     <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_q <= RESP;
                end
                RESP: begin
                    // Both done flags stay set here, which keeps aw_open/w_open low.
                    if (b_hs) begin
                        state_q     <= IDLE;
                        grant_q     <= '0;
                        grant_idx_q <= '0;
                        busy_q      <= 1'b0;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;
    assign aw_open   = busy_q && !aw_done_q;
    assign w_open    = busy_q && !w_done_q;

`ifndef SYNTHESIS
    a_aw_dup: assert property (@(posedge aclk) disable iff (!aresetn) !(aw_hs && busy_q && aw_done_q))
        else $error("aw_hs after AW already completed");
    a_w_dup: assert property (@(posedge aclk) disable iff (!aresetn) !(w_hs && busy_q && w_done_q))
        else $error("w_hs after W already completed");
    a_onehot: assert property (@(posedge aclk) disable iff (!aresetn) $onehot0(grant_q))
        else $error("grant not one-hot");
`endif

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Randomized and directed bench for axil_wr_arbiter against a transaction-level model.
module tb_axil_wr_arbiter;

    localparam int NM = 4;
    localparam int IW = 2;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [NM-1:0] req;
    logic          aw_hs, w_hs, b_hs;
    logic [NM-1:0] grant;
    logic [IW-1:0] grant_idx;
    logic          busy, aw_open, w_open;

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the slave (-1 = free), which phases it has finished, last winner.
    int owner;
    bit aw_seen, w_seen;
    int last_win;

    axil_wr_arbiter #(.NUMBER_MASTER(NM)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req       (req),
        .aw_hs     (aw_hs),
        .w_hs      (w_hs),
        .b_hs      (b_hs),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .aw_open   (aw_open),
        .w_open    (w_open)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [NM-1:0] r);
        int start;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
        start = (last_win + 1) % NM;
`else
        start = 0;
`endif
        for (int k = 0; k < NM; k++) begin
            if (r[(start + k) % NM]) return (start + k) % NM;
        end
        return -1;
    endfunction

    task automatic model_reset();
        owner    = -1;
        aw_seen  = 1'b0;
        w_seen   = 1'b0;
        last_win = 0;
    endtask

    task automatic model_step();
        int p;
        if (owner < 0) begin
            p = model_pick(req);
            if (p >= 0) begin
                owner    = p;
                last_win = p;
                aw_seen  = 1'b0;
                w_seen   = 1'b0;
            end
        end else if (aw_seen && w_seen) begin
            if (b_hs) owner = -1;
        end else begin
            aw_seen = aw_seen | aw_hs;
            w_seen  = w_seen | w_hs;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NM-1:0] exp_grant;
        exp_grant = (owner >= 0) ? NM'(1 << owner) : '0;
        check({tag, "_grant"}, 32'(grant), 32'(exp_grant));
        check({tag, "_busy"}, 32'(busy), 32'(owner >= 0));
        check({tag, "_aw_open"}, 32'(aw_open), 32'(owner >= 0 && !aw_seen));
        check({tag, "_w_open"}, 32'(w_open), 32'(owner >= 0 && !w_seen));
        if (owner >= 0) check({tag, "_idx"}, 32'(grant_idx), 32'(owner));
    endtask

    // Drive at the falling edge, let the rising edge act, compare at the next falling edge.
    task automatic cycle(input logic [NM-1:0] r, input logic a, input logic w, input logic b,
                         input string tag);
        req   = r;
        aw_hs = a;
        w_hs  = w;
        b_hs  = b;
        @(posedge aclk);
        model_step();
        @(negedge aclk);
        check_outputs(tag);
    endtask

    initial begin
        aresetn = 1'b0;
        req     = '0;
        aw_hs   = 1'b0;
        w_hs    = 1'b0;
        b_hs    = 1'b0;
        model_reset();
        repeat (3) @(negedge aclk);
        check_outputs("rst");
        aresetn = 1'b1;

        repeat (10) cycle('0, 0, 0, 0, "idle");

        cycle(4'b1010, 0, 0, 0, "tp2");
        check("tp2_grant_const", 32'(grant), 32'h2);
        check("tp2_idx_const", 32'(grant_idx), 32'd1);
        cycle(4'b1010, 0, 0, 0, "tp2");
        cycle(4'b1010, 1, 0, 0, "tp2");
        cycle(4'b1010, 0, 0, 0, "tp2");
        cycle(4'b1010, 0, 1, 0, "tp2");
        check("tp2_resp_aw_open", 32'(aw_open), 32'd0);
        cycle(4'b0000, 0, 0, 0, "tp2");
        cycle(4'b0000, 0, 0, 1, "tp2");
        check("tp2_release", 32'(grant), 32'h0);

        cycle(4'b0001, 0, 0, 0, "tp3");
        cycle(4'b0000, 0, 0, 1, "tp3_b_ignored");
        check("tp3_busy_kept", 32'(busy), 32'd1);
        cycle(4'b0000, 1, 1, 0, "tp3");
        check("tp3_opens", 32'({aw_open, w_open}), 32'd0);
        cycle(4'b0000, 0, 0, 1, "tp3");

        for (int t = 0; t < 6; t++) begin
            cycle(4'b1111, 0, 0, 0, "tp4");
`ifndef AXIL_ARB_ROUND_ROBIN_EN
            check("tp4_fixed_grant", 32'(grant), 32'h1);
`endif
            cycle(4'b1111, 1, 1, 0, "tp4");
            cycle(4'b1111, 0, 0, 1, "tp4");
        end

        cycle(4'b0100, 0, 0, 0, "tp5");
        cycle(4'b0001, 0, 0, 0, "tp5");
        check("tp5_hold", 32'(grant), 32'h4);
        cycle(4'b0001, 1, 0, 0, "tp5");
        cycle(4'b0001, 0, 1, 0, "tp5");
        check("tp5_hold_resp", 32'(grant), 32'h4);
        cycle(4'b0001, 0, 0, 1, "tp5");
        cycle(4'b0000, 0, 0, 0, "tp5");

        cycle(4'b0100, 0, 0, 0, "tp6");
        cycle(4'b0100, 1, 1, 0, "tp6");
        #2 aresetn = 1'b0;
        #1;
        model_reset();
        check("tp6_async_grant", 32'(grant), 32'h0);
        check("tp6_async_busy", 32'(busy), 32'd0);
        check_outputs("tp6_rst");
        @(negedge aclk);
        aresetn = 1'b1;
        cycle(4'b0100, 0, 0, 0, "tp6");
        check("tp6_regrant", 32'(grant), 32'h4);
        check("tp6_regrant_idx", 32'(grant_idx), 32'd2);

        for (int n = 0; n < 800; n++) begin
            logic a, w, b;
            a = (owner >= 0 && !aw_seen) && ($urandom_range(0, 2) == 0);
            w = (owner >= 0 && !w_seen) && ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 3) == 0);
            cycle(NM'($urandom), a, w, b, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
